// File: rtl/grid_renderer_if.sv
// Pixel-stream bundle between the VGA timing side and the grid renderer.
//   master: drives x, y, video_on, cells, error, cursor_en, cursor_row, cursor_col;
//           receives rgb, video_on_d.
//   slave : the renderer, with the directions reversed.
// ROWS/COLS must match the renderer instance they connect to.
interface grid_renderer_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [9:0]             x;
  logic [9:0]             y;
  logic                   video_on;
  logic [ROWS*COLS*12-1:0] cells;
  logic                   error;
  logic                   cursor_en;
  logic [RIW-1:0]         cursor_row;
  logic [CIW-1:0]         cursor_col;
  logic [11:0]            rgb;
  logic                   video_on_d;

  modport master (
    output x, y, video_on, cells, error, cursor_en, cursor_row, cursor_col,
    input  rgb, video_on_d
  );

  modport slave (
    input  x, y, video_on, cells, error, cursor_en, cursor_row, cursor_col,
    output rgb, video_on_d
  );
endinterface

// File: rtl/grid_renderer.sv
// Renders a ROWS x COLS grid of solid-colour cells, separated by gaps and
// surrounded by a frame border, into a 12-bit VGA pixel stream.
// Two registered stages: classify the pixel, then pick its colour.
// All cell/error/cursor inputs are snapshotted at pixel (0,0) so a frame
// never tears. The border blinks while error is held.
// Ports:
//   clk   - pixel clock
//   rst_n - asynchronous active-low reset
//   bus   - grid_renderer_if.slave (pixel position/qualifier, cell colours,
//           error, cursor controls in; rgb and video_on_d out, latency 2)
module grid_renderer #(
  parameter int          ROWS         = 4,
  parameter int          COLS         = 4,
  parameter int          CELL         = 100,
  parameter int          GAP          = 4,
  parameter int          BORDER_X     = 110,
  parameter int          BORDER_Y     = 30,
  parameter int          CURSOR_W     = 2,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] BORDER_COLOR = 12'h606,
  parameter logic [11:0] ERROR_COLOR  = 12'hFFF,
  parameter logic [11:0] GAP_COLOR    = 12'h7FF,
  parameter logic [11:0] CURSOR_COLOR = 12'hFF0
) (
  input logic            clk,
  input logic            rst_n,
  grid_renderer_if.slave bus
);

  localparam int P   = CELL + GAP;
  localparam int GW  = COLS * P + GAP;
  localparam int GH  = ROWS * P + GAP;
  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int NW  = ROWS * COLS * 12;
  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int BLINK_LAST = (BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0;

  localparam logic [11:0] X_LO    = 12'(BORDER_X);
  localparam logic [11:0] X_HI    = 12'(BORDER_X + GW);
  localparam logic [11:0] Y_LO    = 12'(BORDER_Y);
  localparam logic [11:0] Y_HI    = 12'(BORDER_Y + GH);
  localparam logic [11:0] GAP_W   = 12'(GAP);
  localparam logic [11:0] NEAR_LO = 12'(GAP + CURSOR_W);
  localparam logic [11:0] NEAR_HI = 12'(GAP + CELL - CURSOR_W);

  typedef enum logic [1:0] {CLS_BORDER, CLS_GAP, CLS_CELL} cls_t;

  // snapshot registers
  logic [NW-1:0]  cells_q;
  logic           err_q;
  logic           cur_en_q;
  logic [RIW-1:0] cur_row_q;
  logic [CIW-1:0] cur_col_q;
  logic [BCW-1:0] blink_cnt;
  logic           blink_ph;

  // stage 1
  cls_t           s1_cls;
  logic [RIW-1:0] s1_row;
  logic [CIW-1:0] s1_col;
  logic           s1_edge;
  logic           s1_vo;

  logic        frame_start;
  logic [11:0] xe, ye, gx, gy, offx, offy;
  logic [RIW-1:0] row_c;
  logic [CIW-1:0] col_c;
  logic        in_grid, edge_c;
  cls_t        cls_c;
  logic [11:0] cell_rgb, rgb_c, rgb_q;
  logic        cursor_hit;
  logic        vod_q;

  assign frame_start = (bus.x == 10'd0) && (bus.y == 10'd0);

  // Row/column found by a constant pitch-boundary chain instead of a divider.
  // The chain also runs to index COLS/ROWS so the trailing gap after the
  // last cell yields an offset below GAP.
  always_comb begin
    xe    = {2'b00, bus.x};
    ye    = {2'b00, bus.y};
    gx    = xe - X_LO;
    gy    = ye - Y_LO;
    col_c = '0;
    row_c = '0;
    offx  = gx;
    offy  = gy;
    for (int unsigned c = 1; c <= COLS; c++) begin
      if (gx >= 12'(c * P)) begin
        offx = gx - 12'(c * P);
        if (c < COLS) col_c = CIW'(c);
      end
    end
    for (int unsigned r = 1; r <= ROWS; r++) begin
      if (gy >= 12'(r * P)) begin
        offy = gy - 12'(r * P);
        if (r < ROWS) row_c = RIW'(r);
      end
    end
    in_grid = (xe >= X_LO) && (xe < X_HI) && (ye >= Y_LO) && (ye < Y_HI);
    edge_c  = (offx < NEAR_LO) || (offx >= NEAR_HI) ||
              (offy < NEAR_LO) || (offy >= NEAR_HI);
    if (!in_grid)                           cls_c = CLS_BORDER;
    else if ((offx < GAP_W) || (offy < GAP_W)) cls_c = CLS_GAP;
    else                                    cls_c = CLS_CELL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_cls  <= CLS_BORDER;
      s1_row  <= '0;
      s1_col  <= '0;
      s1_edge <= 1'b0;
      s1_vo   <= 1'b0;
    end else begin
      s1_cls  <= cls_c;
      s1_row  <= row_c;
      s1_col  <= col_c;
      s1_edge <= edge_c;
      s1_vo   <= bus.video_on;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells_q   <= '0;
      err_q     <= 1'b0;
      cur_en_q  <= 1'b0;
      cur_row_q <= '0;
      cur_col_q <= '0;
    end else if (frame_start) begin
      cells_q   <= bus.cells;
      err_q     <= bus.error;
      cur_en_q  <= bus.cursor_en;
      cur_row_q <= bus.cursor_row;
      cur_col_q <= bus.cursor_col;
    end
  end

  // A rising error restarts in the "on" phase so the first error frame shows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else if (frame_start) begin
      if (!bus.error || !err_q) begin
        blink_cnt <= '0;
        blink_ph  <= 1'b1;
      end else if (BLINK_FRAMES > 0) begin
        if (blink_cnt == BCW'(BLINK_LAST)) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // stage 2: colour select
  always_comb begin
    cell_rgb = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if ((s1_row == RIW'(r)) && (s1_col == CIW'(c)))
          cell_rgb = cells_q[(r*COLS + c)*12 +: 12];
      end
    end
    // out-of-range cursor coordinates never equal a classified row/col
    cursor_hit = cur_en_q && (s1_row == cur_row_q) && (s1_col == cur_col_q) && s1_edge;
    rgb_c = '0;
    if (s1_vo) begin
      case (s1_cls)
        CLS_BORDER: rgb_c = (err_q && blink_ph) ? ERROR_COLOR : BORDER_COLOR;
        CLS_GAP:    rgb_c = GAP_COLOR;
        CLS_CELL:   rgb_c = cursor_hit ? CURSOR_COLOR : cell_rgb;
        default:    rgb_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
      vod_q <= 1'b0;
    end else begin
      rgb_q <= rgb_c;
      vod_q <= s1_vo;
    end
  end

  assign bus.rgb        = rgb_q;
  assign bus.video_on_d = vod_q;

endmodule

// File: tb/tb_grid_renderer.sv
module tb_grid_renderer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  grid_renderer_if #(.ROWS(4), .COLS(4)) b1 ();
  grid_renderer_if #(.ROWS(5), .COLS(4)) b2 ();

  grid_renderer #(.ROWS(4), .COLS(4), .BLINK_FRAMES(2)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  grid_renderer #(.ROWS(5), .COLS(4), .BLINK_FRAMES(2)) u2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2)
  );

  // second instance (5 rows) follows the first except for its cursor row
  assign b2.x          = b1.x;
  assign b2.y          = b1.y;
  assign b2.video_on   = b1.video_on;
  assign b2.cells      = {48'h0, b1.cells};
  assign b2.error      = b1.error;
  assign b2.cursor_en  = b1.cursor_en;
  assign b2.cursor_col = b1.cursor_col;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vo;
    logic [11:0] exp;
    logic        chk2;
    logic [11:0] exp2;
  } vec_t;

  vec_t geo [11];
  vec_t cur [8];
  logic [11:0] blink_exp [6];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // inputs held two cycles, result checked once the pipeline has delivered it
  task automatic pix(input logic [9:0] px, input logic [9:0] py, input logic vo,
                     input logic [11:0] exp, input string name);
    b1.x = px;
    b1.y = py;
    b1.video_on = vo;
    @(posedge clk);
    @(posedge clk);
    #1;
    check(name, b1.rgb, exp);
    check({name, "/vod"}, {11'd0, b1.video_on_d}, {11'd0, vo});
  endtask

  // exactly one cycle at (0,0)
  task automatic frame_start();
    b1.x = 10'd0;
    b1.y = 10'd0;
    b1.video_on = 1'b1;
    @(posedge clk);
    #1;
    b1.x = 10'd1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    b1.x = '0; b1.y = '0; b1.video_on = 1'b0; b1.cells = '0; b1.error = 1'b0;
    b1.cursor_en = 1'b0; b1.cursor_row = 2'd0; b1.cursor_col = 2'd0;
    b2.cursor_row = 3'd0;

    geo = '{
      '{10'd330, 10'd140, 1'b1, 12'hABC, 1'b1, 12'hABC},
      '{10'd214, 10'd50,  1'b1, 12'h7FF, 1'b1, 12'h7FF},
      '{10'd109, 10'd50,  1'b1, 12'h606, 1'b1, 12'h606},
      '{10'd110, 10'd50,  1'b1, 12'h7FF, 1'b1, 12'h7FF},
      '{10'd530, 10'd50,  1'b1, 12'h606, 1'b1, 12'h606},
      '{10'd330, 10'd450, 1'b1, 12'h606, 1'b0, 12'h000},
      '{10'd120, 10'd40,  1'b1, 12'h111, 1'b1, 12'h111},
      '{10'd330, 10'd140, 1'b0, 12'h000, 1'b1, 12'h000},
      '{10'd529, 10'd449, 1'b1, 12'h7FF, 1'b1, 12'h7FF},
      '{10'd114, 10'd34,  1'b1, 12'h111, 1'b1, 12'h111},
      '{10'd113, 10'd34,  1'b1, 12'h7FF, 1'b1, 12'h7FF}
    };
    // exp: cursor at (1,2); exp2: cursor row 5 is out of range in 5-row grid
    cur = '{
      '{10'd322, 10'd138, 1'b1, 12'hFF0, 1'b1, 12'hABC},
      '{10'd323, 10'd139, 1'b1, 12'hFF0, 1'b1, 12'hABC},
      '{10'd421, 10'd237, 1'b1, 12'hFF0, 1'b1, 12'hABC},
      '{10'd324, 10'd140, 1'b1, 12'hABC, 1'b1, 12'hABC},
      '{10'd421, 10'd140, 1'b1, 12'hFF0, 1'b1, 12'hABC},
      '{10'd330, 10'd237, 1'b1, 12'hFF0, 1'b1, 12'hABC},
      '{10'd320, 10'd140, 1'b1, 12'h7FF, 1'b1, 12'h7FF},
      '{10'd114, 10'd34,  1'b1, 12'h111, 1'b1, 12'h111}
    };
    blink_exp = '{12'h606, 12'hFFF, 12'hFFF, 12'h606, 12'h606, 12'hFFF};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset rgb", b1.rgb, 12'h000);
    check("reset vod", {11'd0, b1.video_on_d}, 12'h000);
    b1.x = 10'd1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // frame with all cells black
    frame_start();
    pix(10'd330, 10'd140, 1'b1, 12'h000, "zero cell");
    pix(10'd214, 10'd50,  1'b1, 12'h7FF, "zero gap");
    pix(10'd5,   10'd5,   1'b1, 12'h606, "zero border");

    // geometry table
    b1.cells[6*12 +: 12] = 12'hABC;
    b1.cells[0 +: 12]    = 12'h111;
    frame_start();
    for (int i = 0; i < 11; i++) begin
      pix(geo[i].x, geo[i].y, geo[i].vo, geo[i].exp, $sformatf("geo%0d", i));
      if (geo[i].chk2) check($sformatf("geo%0d/u2", i), b2.rgb, geo[i].exp2);
    end

    // snapshot: mid-frame change invisible until next frame start
    b1.cells[6*12 +: 12] = 12'h123;
    pix(10'd330, 10'd140, 1'b1, 12'hABC, "snap hold");
    pix(10'd331, 10'd141, 1'b1, 12'hABC, "snap hold2");
    frame_start();
    pix(10'd330, 10'd140, 1'b1, 12'h123, "snap new");
    b1.cells[6*12 +: 12] = 12'hABC;

    // cursor
    b1.cursor_en  = 1'b1;
    b1.cursor_row = 2'd1;
    b1.cursor_col = 2'd2;
    b2.cursor_row = 3'd5;
    frame_start();
    for (int i = 0; i < 8; i++) begin
      pix(cur[i].x, cur[i].y, cur[i].vo, cur[i].exp, $sformatf("cur%0d", i));
      if (cur[i].chk2) check($sformatf("cur%0d/u2", i), b2.rgb, cur[i].exp2);
    end
    b2.cursor_row = 3'd1;
    frame_start();
    pix(10'd322, 10'd138, 1'b1, 12'hFF0, "cur row1");
    check("cur row1/u2", b2.rgb, 12'hFF0);
    b1.cursor_en = 1'b0;
    frame_start();
    pix(10'd322, 10'd138, 1'b1, 12'hABC, "cur off");

    // blink: error raised mid-frame 0
    frame_start();
    b1.error = 1'b1;
    pix(10'd5, 10'd5, 1'b1, blink_exp[0], "blink f0");
    for (int k = 1; k < 6; k++) begin
      frame_start();
      pix(10'd5, 10'd5, 1'b1, blink_exp[k], $sformatf("blink f%0d", k));
      check($sformatf("blink f%0d/u2", k), b2.rgb, blink_exp[k]);
    end
    b1.error = 1'b0;
    frame_start();
    pix(10'd5, 10'd5, 1'b1, 12'h606, "blink off");

    // asynchronous reset mid-line, then snapshot is zero until a frame start
    frame_start();
    pix(10'd330, 10'd140, 1'b1, 12'hABC, "pre reset");
    rst_n = 1'b0;
    #1;
    check("async rst rgb", b1.rgb, 12'h000);
    check("async rst vod", {11'd0, b1.video_on_d}, 12'h000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pix(10'd330, 10'd140, 1'b1, 12'h000, "post reset snap0");
    frame_start();
    pix(10'd330, 10'd140, 1'b1, 12'hABC, "post reset reload");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
